// File: rtl/usb_pkg.sv
// usb_pkg: shared USB transmit constants, state type and helper function
// Contents: PID codes, SYNC byte, CRC16 polynomial/init, tx FSM states, 16-bit bit reversal.
package usb_pkg;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [7:0] SYNC_BYTE = 8'h80;
   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;
   typedef enum logic [2:0] {
      ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC, ST_EOP_SE0, ST_EOP_J
   } tx_state_e;
   function automatic logic [15:0] rev16(input logic [15:0] v);
      for (int i = 0; i < 16; i++) rev16[i] = v[15-i];
   endfunction
endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: serial CRC16 (poly 0x8005, init 0xFFFF), one payload bit per enable, LSB-first data
// Ports: clk/rst clock and async reset; init reloads the seed; en shifts in din;
// crc is the register bit-reversed, so crc[0] is the first bit to put on the wire.
module usb_crc16
   import usb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);
   logic [15:0] r;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r <= CRC16_INIT;
      else if (init) r <= CRC16_INIT;
      else if (en) r <= {r[14:0], 1'b0} ^ ((r[15] ^ din) ? CRC16_POLY : 16'h0000);
   end
   assign crc = rev16(r);
endmodule

// File: rtl/usb_fs_tx.sv
// usb_fs_tx: USB packet transmitter emitting SYNC, PID, payload, optional CRC16 and EOP with bit stuffing and NRZI
// Ports: useClk/reset clock and async reset; tx_start/tx_pid/tx_zlp request a packet;
// tx_data/tx_valid/tx_last/tx_ready payload stream; tx_busy/tx_done/tx_err status; dp/dn/oe line drive.
// Build option: define USB_TX_CRC16_EN to append a generated CRC16 to DATAx packets.
module usb_fs_tx
   import usb_pkg::*;
#(
   parameter int CLK_DIV     = 10,
   parameter bit LOW_SPEED   = 1'b0,
   parameter int STUFF_LIMIT = 6
) (
   input  logic       useClk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [3:0] tx_pid,
   input  logic       tx_zlp,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   output logic       dp,
   output logic       dn,
   output logic       oe
);
   localparam int OW = $clog2(STUFF_LIMIT + 1);
   tx_state_e state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [3:0] idx, idx_n, pid, pid_n;
   logic [15:0] sh, sh_n;
   logic [OW-1:0] ones, ones_n;
   logic zlp, zlp_n, last, last_n, level, level_n, oe_n, done, done_n;
   logic strobe, stuff, emit;
   assign strobe = (state != ST_IDLE) && (cnt == 8'(CLK_DIV - 1));
   // a stuffed 0 takes precedence over whatever would come next, including the EOP
   assign stuff = strobe && (state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC}) && (ones == OW'(STUFF_LIMIT));
`ifdef USB_TX_CRC16_EN
   logic [15:0] crc;
   usb_crc16 u_crc (
      .clk(useClk),
      .rst(reset),
      .init(state == ST_IDLE),
      .en(emit && !stuff && state_n == ST_DATA),
      .din(sh_n[0]),
      .crc(crc)
   );
`endif
   always_comb begin
      state_n = state;
      cnt_n = strobe ? 8'd0 : cnt + 8'd1;
      idx_n = idx;
      sh_n = sh;
      pid_n = pid;
      zlp_n = zlp;
      last_n = last;
      level_n = level;
      oe_n = oe;
      ones_n = ones;
      done_n = 1'b0;
      emit = stuff;
      tx_ready = 1'b0;
      tx_err = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_n = 8'd0;
            if (tx_start) begin
               state_n = ST_SYNC;
               idx_n = 4'd0;
               sh_n = {8'h00, SYNC_BYTE};
               pid_n = tx_pid;
               zlp_n = tx_zlp;
               last_n = 1'b0;
               ones_n = '0;
               oe_n = 1'b1;
               emit = 1'b1;
            end
         end
         ST_EOP_SE0: if (strobe) begin
            idx_n = idx + 4'd1;
            if (idx == 4'd1) begin
               state_n = ST_EOP_J;
               level_n = 1'b1;
            end
         end
         ST_EOP_J: if (strobe) begin
            state_n = ST_IDLE;
            oe_n = 1'b0;
            done_n = 1'b1;
         end
         default: if (strobe && !stuff) begin
            if (idx != (state == ST_CRC ? 4'd15 : 4'd7)) begin
               idx_n = idx + 4'd1;
               sh_n = sh >> 1;
               emit = 1'b1;
            end else begin
               idx_n = 4'd0;
               if (state == ST_SYNC) begin
                  state_n = ST_PID;
                  sh_n = {8'h00, ~pid, pid};
                  emit = 1'b1;
               end else if (state != ST_CRC && pid[1:0] == 2'b11 && !zlp && !last) begin
                  tx_ready = 1'b1;
                  if (tx_valid) begin
                     state_n = ST_DATA;
                     sh_n = {8'h00, tx_data};
                     last_n = tx_last;
                     emit = 1'b1;
                  end else begin
                     state_n = ST_EOP_SE0;
                     tx_err = 1'b1;
                  end
               end
`ifdef USB_TX_CRC16_EN
               else if (state != ST_CRC && pid[1:0] == 2'b11) begin
                  state_n = ST_CRC;
                  sh_n = ~crc;
                  emit = 1'b1;
               end
`endif
               else state_n = ST_EOP_SE0;
            end
         end
      endcase
      // NRZI: level 1 means J; a 0 (data or stuffed) toggles the line
      if (emit) begin
         level_n = (stuff || !sh_n[0]) ? ~level : level;
         ones_n = (stuff || !sh_n[0]) ? '0 : ones + 1'b1;
      end
   end
   always_ff @(posedge useClk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt <= '0;
         idx <= '0;
         sh <= '0;
         pid <= '0;
         zlp <= 1'b0;
         last <= 1'b0;
         level <= 1'b1;
         oe <= 1'b0;
         ones <= '0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         idx <= idx_n;
         sh <= sh_n;
         pid <= pid_n;
         zlp <= zlp_n;
         last <= last_n;
         level <= level_n;
         oe <= oe_n;
         ones <= ones_n;
         done <= done_n;
      end
   end
   assign tx_busy = state != ST_IDLE;
   assign tx_done = done;
   assign dp = (state == ST_EOP_SE0) ? 1'b0 : level ^ LOW_SPEED;
   assign dn = (state == ST_EOP_SE0) ? 1'b0 : ~(level ^ LOW_SPEED);
endmodule

// File: tb/tb_usb_fs_tx.sv
// tb_usb_fs_tx: directed bench for usb_fs_tx decoding the NRZI/stuffed line back to bytes
module tb_usb_fs_tx;
   import usb_pkg::*;
   logic clk = 1'b0, reset = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0, tx_zlp = 1'b0, tx_valid = 1'b0, tx_last = 1'b0;
   logic [3:0] tx_pid = 4'h0;
   logic [7:0] tx_data = 8'h00;
   logic rdy0, busy0, done0, err0, dp0, dn0, oe0;
   logic rdy1, busy1, done1, err1, dp1, dn1, oe1;
   int tests = 0, fails = 0, sel = 0;
   logic [1:0] sym [64];
   logic [7:0] db [8];
   logic [7:0] q [4];
   int nsym, nbytes, stuffs, stuff_bad, qn, last_at;
   int oe_cyc, rdy_n, err_n, done_n, rdy_c0, rdy_c1, err_c;
   logic eop_ok, busy_at0, busy_at_done, fin;
   wire s_dp = (sel != 0) ? dp1 : dp0;
   wire s_dn = (sel != 0) ? dn1 : dn0;
   wire s_oe = (sel != 0) ? oe1 : oe0;
   wire s_rdy = (sel != 0) ? rdy1 : rdy0;
   wire s_err = (sel != 0) ? err1 : err0;
   wire s_done = (sel != 0) ? done1 : done0;
   wire s_busy = (sel != 0) ? busy1 : busy0;

   always #5 clk = ~clk;

   usb_fs_tx #(.CLK_DIV(10)) dut0 (
      .useClk(clk), .reset(reset), .tx_start(start0), .tx_pid(tx_pid), .tx_zlp(tx_zlp),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(rdy0),
      .tx_busy(busy0), .tx_done(done0), .tx_err(err0), .dp(dp0), .dn(dn0), .oe(oe0));
   usb_fs_tx #(.CLK_DIV(80), .LOW_SPEED(1'b1)) dut1 (
      .useClk(clk), .reset(reset), .tx_start(start1), .tx_pid(tx_pid), .tx_zlp(tx_zlp),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(rdy1),
      .tx_busy(busy1), .tx_done(done1), .tx_err(err1), .dp(dp1), .dn(dn1), .oe(oe1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends one packet and samples the line mid-bit; ends in the tx_done cycle.
   task automatic run(input int s, input int div, input logic [3:0] pid, input logic zlp, input int ign_at);
      int c, qi;
      bit pend;
      sel = s;
      nsym = 0; oe_cyc = 0; rdy_n = 0; err_n = 0; done_n = 0;
      rdy_c0 = -1; rdy_c1 = -1; err_c = -1; fin = 1'b0; busy_at0 = 1'b0; busy_at_done = 1'b1;
      qi = 0; pend = 1'b0;
      tx_pid = pid; tx_zlp = zlp;
      tx_valid = (qn > 0); tx_data = (qn > 0) ? q[0] : 8'h00; tx_last = (last_at == 0);
      if (s != 0) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      c = 0;
      while (!fin && c < 60 * div) begin
         if (pend) begin
            qi++;
            tx_valid = (qi < qn);
            tx_data = (qi < qn) ? q[qi] : 8'h00;
            tx_last = (qi == last_at);
            pend = 1'b0;
         end
         start0 = (s == 0) && (c == ign_at);
         #1;
         if (c == 0) busy_at0 = s_busy;
         if (s_oe) oe_cyc++;
         if (s_oe && (c % div) == div / 2 && nsym < 64) begin
            sym[nsym] = {s_dp, s_dn};
            nsym++;
         end
         if (s_rdy) begin
            rdy_n++;
            if (rdy_c0 < 0) rdy_c0 = c;
            rdy_c1 = c;
            if (tx_valid) pend = 1'b1;
         end
         if (s_err) begin err_n++; err_c = c; end
         if (s_done) begin done_n++; fin = 1'b1; busy_at_done = s_busy; end
         if (!fin) begin
            @(negedge clk);
            c++;
         end
      end
      start0 = 1'b0;
      chk("finished_in_time", fin, 1'b1);
   endtask

   task automatic decode(input logic [1:0] j);
      logic [1:0] prev;
      logic b;
      int ones, nb;
      prev = j; ones = 0; nb = 0; stuffs = 0; stuff_bad = 0;
      for (int i = 0; i < 8; i++) db[i] = 8'h00;
      eop_ok = (nsym >= 3) && sym[nsym-3] == 2'b00 && sym[nsym-2] == 2'b00 && sym[nsym-1] == j;
      for (int i = 0; i < nsym - 3; i++) begin
         b = (sym[i] == prev);
         prev = sym[i];
         if (ones == 6) begin
            stuffs++;
            ones = 0;
            if (b) stuff_bad++;
         end else begin
            ones = b ? ones + 1 : 0;
            if (nb < 64) db[nb/8][nb%8] = b;
            nb++;
         end
      end
      nbytes = (nb % 8 == 0) ? nb / 8 : -1;
   endtask

`ifdef USB_TX_CRC16_EN
   function automatic logic [15:0] crc_ref(input int n);
      logic [15:0] c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c ^= {8'h00, q[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return ~c;
   endfunction
`endif

   initial begin
      qn = 0; last_at = -1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_oe", oe0, 1'b0);
      chk("rst_line", {dp0, dn0}, 2'b10);
      chk("rst_flags", {busy0, rdy0, done0, err0}, 4'b0000);
      chk("rst_ls_line", {dp1, dn1, oe1}, 3'b010);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("idle_oe", oe0, 1'b0);
      chk("idle_busy", busy0, 1'b0);

      // ACK, with a second tx_start mid-packet that must be ignored
      run(0, 10, PID_ACK, 1'b0, 50);
      decode(2'b10);
      chk("ack_nsym", nsym, 19);
      chk("ack_oe_cycles", oe_cyc, 190);
      chk("ack_sync", db[0], 8'h80);
      chk("ack_pid", db[1], 8'hD2);
      chk("ack_nbytes", nbytes, 2);
      chk("ack_stuffs", stuffs, 0);
      chk("ack_eop", eop_ok, 1'b1);
      chk("ack_done", done_n, 1);
      chk("ack_ready", rdy_n, 0);
      chk("ack_busy_start", busy_at0, 1'b1);
      chk("ack_busy_done", busy_at_done, 1'b0);

      // back-to-back DATA0 zero-length packet
      run(0, 10, PID_DATA0, 1'b1, -1);
      decode(2'b10);
      chk("zlp_sync", db[0], 8'h80);
      chk("zlp_pid", db[1], 8'hC3);
      chk("zlp_ready", rdy_n, 0);
      chk("zlp_stuffs", stuffs, 0);
      chk("zlp_eop", eop_ok, 1'b1);
`ifdef USB_TX_CRC16_EN
      chk("zlp_nsym", nsym, 35);
      chk("zlp_crc", {db[3], db[2]}, 16'h0000);
`else
      chk("zlp_nsym", nsym, 19);
      chk("zlp_nbytes", nbytes, 2);
`endif

      // DATA1 0xFF 0xFF exercises stuffing and ready slip
      q[0] = 8'hFF; q[1] = 8'hFF; qn = 2; last_at = 1;
      run(0, 10, PID_DATA1, 1'b0, -1);
      decode(2'b10);
      chk("ff_pid", db[1], 8'h4B);
      chk("ff_b0", db[2], 8'hFF);
      chk("ff_b1", db[3], 8'hFF);
      chk("ff_ready_n", rdy_n, 2);
      chk("ff_ready_first", rdy_c0, 159);
      chk("ff_ready_slip", rdy_c1, 249);
      chk("ff_err", err_n, 0);
      chk("ff_stuff_zero", stuff_bad, 0);
      chk("ff_eop", eop_ok, 1'b1);
`ifdef USB_TX_CRC16_EN
      chk("ff_nbytes", nbytes, 6);
      chk("ff_crc", {db[5], db[4]}, crc_ref(2));
`else
      chk("ff_nbytes", nbytes, 4);
      chk("ff_stuffs", stuffs, 2);
      chk("ff_nsym", nsym, 37);
`endif

      // underrun before the second byte
      q[0] = 8'h12; qn = 1; last_at = -1;
      run(0, 10, PID_DATA0, 1'b0, -1);
      decode(2'b10);
      chk("ur_err_n", err_n, 1);
      chk("ur_err_cycle", err_c, 239);
      chk("ur_ready_n", rdy_n, 2);
      chk("ur_b0", db[2], 8'h12);
      chk("ur_nbytes", nbytes, 3);
      chk("ur_nsym", nsym, 27);
      chk("ur_eop", eop_ok, 1'b1);
      chk("ur_done", done_n, 1);

      // reset in the middle of a data byte
      qn = 0;
      tx_pid = PID_DATA0; tx_zlp = 1'b0; tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b0;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (200) @(negedge clk);
      #1;
      chk("mid_busy", busy0, 1'b1);
      reset = 1'b1;
      #1;
      chk("mid_rst_oe", oe0, 1'b0);
      chk("mid_rst_busy", busy0, 1'b0);
      chk("mid_rst_line", {dp0, dn0}, 2'b10);
      @(negedge clk);
      reset = 1'b0;
      tx_valid = 1'b0;
      @(negedge clk);
      run(0, 10, PID_ACK, 1'b0, -1);
      decode(2'b10);
      chk("post_rst_pid", db[1], 8'hD2);
      chk("post_rst_nsym", nsym, 19);
      chk("post_rst_eop", eop_ok, 1'b1);

      // low-speed NAK
      sel = 1;
      #1;
      chk("ls_idle_line", {s_dp, s_dn}, 2'b01);
      run(1, 80, PID_NAK, 1'b0, -1);
      decode(2'b01);
      chk("ls_sync", db[0], 8'h80);
      chk("ls_pid", db[1], 8'h5A);
      chk("ls_nsym", nsym, 19);
      chk("ls_oe_cycles", oe_cyc, 1520);
      chk("ls_eop", eop_ok, 1'b1);
      chk("ls_done", done_n, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
